// File: rtl/pipeline_pkg.sv
// Shared widths, reset PC and fetch-sequencer state encoding for the front-end pipeline.
package pipeline_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          INST_W   = 32;
    localparam int          ADDR_W   = 32;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is visible combinationally on data_o.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 data_i,
    output logic [W-1:0]                 data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // NOTE: storage is not reset; validity comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch sequencer with prefetch FIFO and redirect squash.
// Optional same-cycle ack-to-decode bypass: define IFETCH_BYPASS_EN.
module ifetch_queue
    import pipeline_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            pc,
    output logic                         pcWrite,
    output logic [ADDR_W-1:0]            pcNext,
    output logic                         imemReq,
    output logic [ADDR_W-1:0]            imemAddr,
    input  logic                         imemAck,
    input  logic [INST_W-1:0]            imemData,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirectTarget,
    output logic                         instValid,
    output logic [INST_W-1:0]            instData,
    output logic [ADDR_W-1:0]            instPC,
    input  logic                         instReady,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = ADDR_W + INST_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] fetch_addr;
    logic              ack_ok, accept, push, pop, fifo_empty;
    logic [EW-1:0]     head;
    logic [CW-1:0]     fifo_count;

    assign fifo_empty = (fifo_count == '0);
    assign count      = fifo_count;
    assign fetch_addr = (state_q == RUN) ? pc : req_addr_q;
    assign imemAddr   = fetch_addr;

    // Strobes are gated by rst_n so a reset mid-fetch drops the request immediately.
    assign imemReq = rst_n && ((state_q != RUN) || (fifo_count < CW'(DEPTH)));
    assign ack_ok  = imemReq && imemAck;
    assign accept  = ack_ok && !redirect && (state_q != DROP);
    assign pcWrite = rst_n && (redirect || accept);
    assign pcNext  = redirect ? redirectTarget
                   : accept   ? fetch_addr + PC_STEP
                   :            pc + PC_STEP;

`ifdef IFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = accept && fifo_empty;
    assign instValid = !fifo_empty || bypass;
    assign instData  = bypass ? imemData   : head[INST_W-1:0];
    assign instPC    = bypass ? fetch_addr : head[EW-1:INST_W];
    assign push      = accept && !(bypass && instReady);
`else
    assign instValid = !fifo_empty;
    assign instData  = head[INST_W-1:0];
    assign instPC    = head[EW-1:INST_W];
    assign push      = accept;
`endif
    assign pop = !fifo_empty && instReady && !redirect;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        if (state_q == RUN && imemReq && !imemAck) begin
            req_addr_d = pc;
        end
        if (redirect) begin
            state_d = (imemReq && !imemAck) ? DROP : RUN;
        end else begin
            case (state_q)
                RUN:       if (imemReq && !imemAck) state_d = WAIT;
                WAIT, DROP: if (imemAck)            state_d = RUN;
                default:                            state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({fetch_addr, imemData}),
        .data_o  (head),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue against a queue-based model of the fetch/buffer rules.
module tb_ifetch_queue;
    import pipeline_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pcWrite;
    logic [31:0] pcNext;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPC;
    logic        instReady;
    logic [2:0]  count;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH   (DEPTH),
        .PC_STEP (STEP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .pcWrite        (pcWrite),
        .pcNext         (pcNext),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemAck        (imemAck),
        .imemData       (imemData),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .instValid      (instValid),
        .instData       (instData),
        .instPC         (instPC),
        .instReady      (instReady),
        .count          (count)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    // Model: buffered entries, plus one outstanding request that may be marked squashed.
    entry_t      q[$];
    bit          pending, dropping;
    logic [31:0] pend_addr;
    int          mem_wait, cur_lat, lat_cfg;
    bit          lat_rand;
    logic [31:0] pop_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic        s_req, s_pcw, s_valid;
    logic [31:0] s_addr, s_pcnext, s_instpc, s_count;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imemAck        = 1'b0;
        imemData       = '0;
        redirect       = 1'b0;
        redirectTarget = '0;
        instReady      = 1'b0;
        pc             = RESET_PC;
        #1;
        check("rst_imemReq",   32'(imemReq),   32'd0);
        check("rst_instValid", 32'(instValid), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_pcWrite",   32'(pcWrite),   32'd0);
        q.delete();
        pop_log.delete();
        pending  = 1'b0;
        dropping = 1'b0;
        mem_wait = 0;
        cur_lat  = lat_rand ? int'($urandom_range(3)) : lat_cfg;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, predict, compare, then advance model and PC register.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
        bit          e_req, ack, acc, good, byp, e_valid, e_pcw, pop, pcw_dut;
        logic [31:0] e_addr, e_pcnext, pcn_dut;
        entry_t      head;

        if (!lat_rand) cur_lat = lat_cfg;
        instReady      = rdy;
        redirect       = redir;
        redirectTarget = tgt;

        e_req  = pending || (q.size() < DEPTH);
        e_addr = pending ? pend_addr : pc;
        ack    = e_req ? (mem_wait >= cur_lat) : ($urandom_range(7) == 0);
        imemAck  = ack;
        imemData = e_req ? mem_word(e_addr) : $urandom;
        acc  = e_req && ack;
        good = acc && !redir && !dropping;
        byp  = 1'b0;
`ifdef IFETCH_BYPASS_EN
        byp = good && (q.size() == 0);
`endif
        e_valid  = (q.size() != 0) || byp;
        head     = byp ? {e_addr, mem_word(e_addr)} : ((q.size() != 0) ? q[0] : '0);
        e_pcw    = redir || good;
        e_pcnext = redir ? tgt : (good ? e_addr + STEP : pc + STEP);

        #2;
        check("imemReq",   32'(imemReq),   32'(e_req));
        if (e_req) check("imemAddr", imemAddr, e_addr);
        check("pcWrite",   32'(pcWrite),   32'(e_pcw));
        check("pcNext",    pcNext,         e_pcnext);
        check("instValid", 32'(instValid), 32'(e_valid));
        check("count",     32'(count),     32'(q.size()));
        if (e_valid) begin
            check("instPC",   instPC,   head.addr);
            check("instData", instData, head.data);
        end
        s_req = imemReq; s_addr = imemAddr; s_pcw = pcWrite; s_pcnext = pcNext;
        s_valid = instValid; s_instpc = instPC; s_count = 32'(count);
        pcw_dut = pcWrite;
        pcn_dut = pcNext;

        pop = e_valid && rdy && !redir;
        if (pop) pop_log.push_back(head.addr);

        @(posedge clk);
        #1;
        if (redir) begin
            q.delete();
        end else if (byp) begin
            if (!rdy) q.push_back(head);
        end else begin
            if (pop)  void'(q.pop_front());
            if (good) q.push_back({e_addr, mem_word(e_addr)});
        end
        if (e_req && !acc) begin
            pending   = 1'b1;
            pend_addr = e_addr;
            dropping  = dropping || redir;
        end else begin
            pending  = 1'b0;
            dropping = 1'b0;
        end
        if (acc) begin
            mem_wait = 0;
            if (lat_rand) cur_lat = int'($urandom_range(3));
        end else if (e_req) begin
            mem_wait++;
        end
        if (pcw_dut) pc = pcn_dut;
    endtask

    initial begin
        rst_n    = 1'b1;
        lat_rand = 1'b0;
        lat_cfg  = 0;
        #1;

        // Zero-wait memory, decode always ready.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, '0);
            check("A_pcWrite", 32'(s_pcw), 32'd1);
        end
        check("A_pop0", pop_log[0], 32'h3000);
        check("A_pop1", pop_log[1], 32'h3004);
        check("A_pop2", pop_log[2], 32'h3008);

        // Decode stall fills the FIFO, then drains in order.
        do_reset();
        repeat (8) step(1'b0, 1'b0, '0);
        check("B_count_full", s_count, 32'd4);
        check("B_req_off",    32'(s_req), 32'd0);
        check("B_pc_hold",    pc, 32'h3010);
        pop_log.delete();
        repeat (4) step(1'b1, 1'b0, '0);
        check("B_drain0", pop_log[0], 32'h3000);
        check("B_drain1", pop_log[1], 32'h3004);
        check("B_drain2", pop_log[2], 32'h3008);
        check("B_drain3", pop_log[3], 32'h300C);

        // Ack arrives in the third request cycle.
        do_reset();
        lat_cfg = 2;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, '0);
            check("C_addr_hold", s_addr, 32'h3000);
            check("C_pcw_pulse", 32'(s_pcw), (k == 2) ? 32'd1 : 32'd0);
        end
        lat_cfg = 0;
        step(1'b1, 1'b0, '0);
        check("C_instPC", pop_log[0], 32'h3000);

        // Redirect while the 0x3008 request is outstanding.
        do_reset();
        repeat (2) step(1'b0, 1'b0, '0);
        lat_cfg = 3;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h4000);
        step(1'b0, 1'b0, '0);
        check("D_flushed",   s_count, 32'd0);
        check("D_drop_addr", s_addr,  32'h3008);
        check("D_drop_req",  32'(s_req), 32'd1);
        step(1'b0, 1'b0, '0);
        lat_cfg = 0;
        pop_log.delete();
        repeat (2) step(1'b1, 1'b0, '0);
        check("D_pop_count", 32'(pop_log.size()), 32'd1);
        check("D_pop_pc",    pop_log[0], 32'h4000);

        // Redirect coinciding with ack and pop, then a wrapping target.
        do_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h5000);
        check("E_pcNext", s_pcnext, 32'h5000);
        step(1'b1, 1'b0, '0);
        check("E_count0", s_count, 32'd0);
        check("E_run_req", 32'(s_req), 32'd1);
        check("E_new_addr", s_addr, 32'h5000);
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0);
        check("E_wrap", s_pcnext, 32'h0000_0000);

        // Reset asserted while waiting on memory.
        do_reset();
        lat_cfg = 5;
        repeat (2) step(1'b0, 1'b0, '0);
        do_reset();
        lat_cfg = 0;
        step(1'b0, 1'b0, '0);
        check("F_first_addr", s_addr, 32'h3000);
        check("F_first_req",  32'(s_req), 32'd1);

`ifdef IFETCH_BYPASS_EN
        do_reset();
        step(1'b1, 1'b0, '0);
        check("G_byp_valid", 32'(s_valid), 32'd1);
        check("G_byp_pc",    s_instpc, 32'h3000);
        step(1'b1, 1'b0, '0);
        check("G_byp_count", s_count, 32'd0);
`endif

        // Random traffic: variable latency, decode stalls, redirects.
        lat_rand = 1'b1;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(9) < 7, $urandom_range(19) == 0, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
